// File: rtl/ifetch_queue.sv
// Instruction-fetch queue: issues imem requests for the current PC and buffers in-order {pc, instr} for decode.
// Optional IFQ_ALIGN_CHECK_EN: misaligned PCs are turned into fault entries instead of being fetched.
`timescale 1ns/1ps

// state | meaning
// IDLE  | after reset, waiting for the first valid PC
// RUN   | issuing requests and queueing responses
// DRAIN | after a flush, dropping responses still in flight
module ifetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] pc_in,
  input  logic          pc_valid,
  output logic          pc_adv,
  input  logic          flush,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [DW-1:0] imem_rdata,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [AW-1:0] inst_pc,
  output logic [DW-1:0] inst_data,
  output logic          inst_fault
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W:0]   DEPTH_X = (CNT_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W-1:0] tag_wr_ptr, tag_rd_ptr;

  logic [AW-1:0]    q_pc   [DEPTH];
  logic [DW-1:0]    q_data [DEPTH];
  logic [DEPTH-1:0] q_fault;
  logic [AW-1:0]    tag_pc [DEPTH];

  logic           misalign;
  logic           can_fetch;
  logic           credit;
  logic [CNT_W:0] inflight;
  logic           mem_issue;
  logic           fault_push;
  logic           rsp_ok;
  logic           rsp_drop;
  logic           rsp_push;
  logic           q_push;
  logic           q_pop;

`ifdef IFQ_ALIGN_CHECK_EN
  assign misalign = (pc_in[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // Queue entries plus in-flight requests never exceed DEPTH, so a response always has a slot.
  assign inflight   = {1'b0, count_q} + {1'b0, out_q};
  assign credit     = (inflight < DEPTH_X);
  assign can_fetch  = (state_q == S_RUN) && pc_valid && !flush;

  assign imem_req   = can_fetch && !misalign && credit;
  assign imem_addr  = imem_req ? pc_in : '0;
  assign mem_issue  = imem_req && imem_gnt;

  // A fault entry waits for older fetches to return so queue order follows PC order.
  assign fault_push = can_fetch && misalign && (count_q < DEPTH_C) && (out_q == '0);
  assign pc_adv     = mem_issue || fault_push;

  // A response with nothing outstanding is ignored entirely.
  assign rsp_ok     = imem_rvalid && (out_q != '0);
  assign rsp_drop   = rsp_ok && (flush || (discard_q != '0));
  assign rsp_push   = rsp_ok && !rsp_drop;

  assign q_push     = rsp_push || fault_push;
  assign q_pop      = inst_valid && inst_ready && !flush;

  always_comb begin
    out_d = out_q;
    if (mem_issue && !rsp_ok) begin
      out_d = out_q + 1'b1;
    end else if (!mem_issue && rsp_ok) begin
      out_d = out_q - 1'b1;
    end

    discard_d = discard_q;
    if (flush) begin
      discard_d = rsp_ok ? (out_q - 1'b1) : out_q;
    end else if (rsp_ok && (discard_q != '0)) begin
      discard_d = discard_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pc_valid) state_d = S_RUN;
      S_RUN:   if (flush && (discard_d != '0)) state_d = S_DRAIN;
      S_DRAIN: if (discard_d == '0) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      out_q     <= '0;
      discard_q <= '0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      discard_q <= discard_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      tag_wr_ptr <= '0;
      tag_rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      tag_wr_ptr <= '0;
      tag_rd_ptr <= '0;
    end else begin
      if (q_push) wr_ptr <= wr_ptr + 1'b1;
      if (q_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (q_push && !q_pop) begin
        count_q <= count_q + 1'b1;
      end else if (!q_push && q_pop) begin
        count_q <= count_q - 1'b1;
      end
      if (mem_issue) tag_wr_ptr <= tag_wr_ptr + 1'b1;
      if (rsp_push)  tag_rd_ptr <= tag_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (q_push) begin
      q_pc[wr_ptr]    <= rsp_push ? tag_pc[tag_rd_ptr] : pc_in;
      q_data[wr_ptr]  <= rsp_push ? imem_rdata : '0;
      q_fault[wr_ptr] <= fault_push;
    end
    if (mem_issue) begin
      tag_pc[tag_wr_ptr] <= pc_in;
    end
  end

  // Head fields read as zero while the queue is empty so outputs are clean out of reset.
  assign inst_valid = (count_q != '0);
  assign inst_pc    = inst_valid ? q_pc[rd_ptr]   : '0;
  assign inst_data  = inst_valid ? q_data[rd_ptr] : '0;
  assign inst_fault = inst_valid && q_fault[rd_ptr];

endmodule
